// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds four BCD digits from a scanned, active-low 7-segment bus.
// Optional watchdog that drops the valid flags when scanning stops: define SEG7_TIMEOUT_EN.
module seg7_scan_decoder #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] iSEG7,
   input  logic [3:0] iDIG_SEL,
   output logic [3:0] oDIG0,
   output logic [3:0] oDIG1,
   output logic [3:0] oDIG2,
   output logic [3:0] oDIG3,
   output logic [3:0] oDIG_VLD,
   output logic       oFRAME,
   output logic       oERR_PAT,
   output logic       oERR_SEL
);
   typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;
   state_t     state, state_nx;
   logic [7:0] stab_cnt, cnt_nx;
   logic [3:0] prev_sel, seen, seen_nx, vld_nx, glyph;
   logic [6:0] prev_seg;
   logic [1:0] idx;
   logic       one_hot, multi, match, capture, legal, timeout;

   always_comb begin
      one_hot = iDIG_SEL != 4'd0 && (iDIG_SEL & (iDIG_SEL - 4'd1)) == 4'd0;
      multi   = iDIG_SEL != 4'd0 && !one_hot;
      match   = one_hot && iDIG_SEL == prev_sel && iSEG7 == prev_seg;
      idx     = iDIG_SEL[1] ? 2'd1 : iDIG_SEL[2] ? 2'd2 : iDIG_SEL[3] ? 2'd3 : 2'd0;
   end

   always_comb begin
      legal = 1'b1;
      case (iSEG7)
         7'h40:   glyph = 4'd0;
         7'h79:   glyph = 4'd1;
         7'h24:   glyph = 4'd2;
         7'h30:   glyph = 4'd3;
         7'h19:   glyph = 4'd4;
         7'h12:   glyph = 4'd5;
         7'h02:   glyph = 4'd6;
         7'h78:   glyph = 4'd7;
         7'h00:   glyph = 4'd8;
         7'h10:   glyph = 4'd9;
         7'h7F:   glyph = 4'hF;
         default: begin
            glyph = 4'h0;
            legal = 1'b0;
         end
      endcase
   end

   // HELD blocks re-capture until the pair changes; any mismatch falls back to IDLE
   always_comb begin
      state_nx = IDLE;
      cnt_nx   = 8'd0;
      capture  = 1'b0;
      if (match) begin
         if (state == HELD)
            state_nx = HELD;
         else if (stab_cnt == 8'(STABLE_CYC - 1)) begin
            capture  = 1'b1;
            state_nx = HELD;
         end else begin
            cnt_nx   = stab_cnt + 8'd1;
            state_nx = COUNT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         stab_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         stab_cnt <= cnt_nx;
      end
   end

`ifdef SEG7_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
   always_ff @(posedge clk) begin
      if (rst || capture)
         to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC))
         to_cnt <= to_cnt + TW'(1);
   end
   assign timeout = !capture && to_cnt == TW'(TIMEOUT_CYC - 1);
`else
   assign timeout = TIMEOUT_CYC < 1;
`endif

   always_comb begin
      vld_nx  = oDIG_VLD;
      seen_nx = seen;
      if (capture) begin
         vld_nx[idx] = legal;
         if (legal)
            seen_nx = (seen | iDIG_SEL) == 4'hF ? 4'h0 : seen | iDIG_SEL;
      end
      if (timeout) begin
         vld_nx  = 4'h0;
         seen_nx = 4'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_sel <= 4'd0;
         prev_seg <= 7'h7F;
         seen     <= 4'd0;
         oDIG_VLD <= 4'd0;
         oDIG0    <= 4'd0;
         oDIG1    <= 4'd0;
         oDIG2    <= 4'd0;
         oDIG3    <= 4'd0;
         oFRAME   <= 1'b0;
         oERR_PAT <= 1'b0;
         oERR_SEL <= 1'b0;
      end else begin
         prev_sel <= iDIG_SEL;
         prev_seg <= iSEG7;
         seen     <= seen_nx;
         oDIG_VLD <= vld_nx;
         oFRAME   <= capture && legal && (seen | iDIG_SEL) == 4'hF;
         oERR_PAT <= capture && !legal;
         oERR_SEL <= multi || timeout;
         if (capture && legal)
            case (idx)
               2'd0:    oDIG0 <= glyph;
               2'd1:    oDIG1 <= glyph;
               2'd2:    oDIG2 <= glyph;
               default: oDIG3 <= glyph;
            endcase
      end
   end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: run-length reference model checked every cycle, plus directed literal checks.
module tb_seg7_scan_decoder;
   localparam int STABLE = 4;
   localparam int TMO    = 50;
   localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic       clk = 1'b0, rst = 1'b1;
   logic [6:0] seg = 7'h55;
   logic [3:0] sel = 4'hF;
   logic [3:0] d0, d1, d2, d3, vld;
   logic       frame, errp, errs;
   int compared = 0, mismatched = 0, frames = 0, errps = 0, errss = 0;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .iSEG7(seg), .iDIG_SEL(sel),
      .oDIG0(d0), .oDIG1(d1), .oDIG2(d2), .oDIG3(d3), .oDIG_VLD(vld),
      .oFRAME(frame), .oERR_PAT(errp), .oERR_SEL(errs)
   );

   // Model: count how many consecutive edges the same one-hot pair has repeated;
   // the pair is captured exactly when that repeat count reaches STABLE.
   logic [3:0] m_dig [4];
   logic [3:0] m_vld, m_seen, last_sel;
   logic [6:0] last_seg;
   logic       m_frame, m_errp, m_errs, cap;
   int         run, idle, n, val;

   always @(posedge clk) begin
      m_frame = 0;
      m_errp  = 0;
      m_errs  = 0;
      cap     = 0;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_dig[i] = 0;
         m_vld = 0; m_seen = 0; last_sel = 0; last_seg = 7'h7F; run = 0; idle = 0;
      end else begin
         if ($countones(sel) > 1) m_errs = 1;
         run = ($countones(sel) == 1 && sel == last_sel && seg == last_seg) ? run + 1 : 0;
         if (run == STABLE) begin
            cap = 1;
            n = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) n = i;
            val = (seg == 7'h7F) ? 15 : -1;
            for (int g = 0; g < 10; g++) if (GLYPH[g] == seg) val = g;
            if (val < 0) begin
               m_vld[n] = 0;
               m_errp = 1;
            end else begin
               m_dig[n] = val[3:0];
               m_vld[n] = 1;
               m_seen[n] = 1;
               if (m_seen == 4'hF) begin
                  m_frame = 1;
                  m_seen = 0;
               end
            end
         end
`ifdef SEG7_TIMEOUT_EN
         if (cap) idle = 0;
         else if (idle < TMO) begin
            idle++;
            if (idle == TMO) begin
               m_vld = 0; m_seen = 0; m_errs = 1;
            end
         end
`endif
         last_sel = sel;
         last_seg = seg;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      chk("dig0", 32'(d0), 32'(m_dig[0]));
      chk("dig1", 32'(d1), 32'(m_dig[1]));
      chk("dig2", 32'(d2), 32'(m_dig[2]));
      chk("dig3", 32'(d3), 32'(m_dig[3]));
      chk("vld", 32'(vld), 32'(m_vld));
      chk("frame", 32'(frame), 32'(m_frame));
      chk("err_pat", 32'(errp), 32'(m_errp));
      chk("err_sel", 32'(errs), 32'(m_errs));
      frames += int'(frame);
      errps  += int'(errp);
      errss  += int'(errs);
   end

   task automatic hold(input logic [3:0] s, input logic [6:0] g, input int cyc);
      @(negedge clk);
      sel = s;
      seg = g;
      repeat (cyc) @(posedge clk);
      #2;
   endtask

   task automatic scan(input logic [6:0] g2);
      hold(4'b0001, 7'h19, 6); hold(4'b0000, 7'h7F, 1);
      hold(4'b0010, 7'h12, 6); hold(4'b0000, 7'h7F, 1);
      hold(4'b0100, g2, 6);    hold(4'b0000, 7'h7F, 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_digits", 32'({d3, d2, d1, d0}), 32'h0);
      chk("rst_flags", 32'({vld, frame, errp, errs}), 32'h0);
      @(negedge clk);
      rst = 0; sel = 4'b0000; seg = 7'h7F;
      repeat (10) @(posedge clk);
      #2;
      chk("idle_outputs", 32'({d3, d2, d1, d0, vld}), 32'h0);
      chk("idle_errsel", 32'(errss), 32'd0);
      // capture latency: visible after the 5th presence edge, not the 4th
      hold(4'b0001, 7'h30, 4);
      chk("pre_capture_vld", 32'(vld), 32'h0);
      hold(4'b0001, 7'h30, 1);
      chk("capture_dig0", 32'(d0), 32'h3);
      chk("capture_vld", 32'(vld), 32'h1);
      hold(4'b0001, 7'h30, 20);
      chk("held_no_pulses", 32'(frames + errps), 32'd0);
      // 4 presence edges are one short of a capture
      hold(4'b0000, 7'h7F, 1);
      hold(4'b0010, 7'h24, 4);
      hold(4'b0000, 7'h7F, 1);
      chk("short_hold_vld", 32'(vld), 32'h1);
      // full legal scan
      scan(7'h02);
      chk("frame_not_early", 32'(frames), 32'd0);
      hold(4'b1000, 7'h7F, 5);
      chk("frame_on_dig3", 32'(frame), 32'h1);
      hold(4'b1000, 7'h7F, 1); hold(4'b0000, 7'h7F, 1);
      chk("scan_digits", 32'({d3, d2, d1, d0}), 32'hF654);
      chk("scan_vld", 32'(vld), 32'hF);
      chk("scan_frames", 32'(frames), 32'd1);
      // same scan with an illegal digit 2
      scan(7'h55);
      hold(4'b1000, 7'h7F, 6); hold(4'b0000, 7'h7F, 1);
      chk("illegal_errpat", 32'(errps), 32'd1);
      chk("illegal_vld", 32'(vld), 32'hB);
      chk("illegal_dig2_kept", 32'(d2), 32'h6);
      chk("illegal_no_frame", 32'(frames), 32'd1);
      // multi-select and glitch
      hold(4'b0011, 7'h40, 3);
      chk("multi_sel_pulses", 32'(errss), 32'd3);
      hold(4'b0000, 7'h7F, 1);
      hold(4'b0001, 7'h79, 2);
      hold(4'b0000, 7'h7F, 2);
      chk("glitch_dig0", 32'(d0), 32'h4);
      chk("glitch_vld", 32'(vld), 32'hB);
      // reset mid-scan discards everything, then recapture
      hold(4'b0100, 7'h24, 2);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #2;
      chk("midreset_clear", 32'({d3, d2, d1, d0, vld}), 32'h0);
      @(negedge clk);
      rst = 0;
      hold(4'b0100, 7'h24, 5);
      chk("post_reset_dig2", 32'(d2), 32'h2);
      chk("post_reset_vld", 32'(vld), 32'h4);
`ifdef SEG7_TIMEOUT_EN
      errss = 0;
      hold(4'b0000, 7'h7F, TMO + 2);
      chk("timeout_vld", 32'(vld), 32'h0);
      chk("timeout_pulse", 32'(errss), 32'd1);
`endif
      hold(4'b0000, 7'h7F, 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the board's multiplexed 7-segment driver. It samples the active-low segment bus and the one-hot digit-select lines of a scanned 4-digit display, and rebuilds the four BCD digit values. A digit value is accepted only after it has been stable for a set number of clocks. The block serves as the loopback checker for the counter/display path and as a pin-level monitor on the display interface.

Parameters:
STABLE_CYC, 4, number of consecutive sampled clock edges a (select, segment) pair must hold before it is captured; legal range 2..255
TIMEOUT_CYC, 1000000, clocks without any capture before the watchdog fires (used only when the optional feature is compiled in)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
iSEG7  input  7  segment bus, active-low, bit order {g,f,e,d,c,b,a}
iDIG_SEL  input  4  digit enables, active-high, bit n selects digit n
oDIG0  output  4  decoded BCD, digit 0
oDIG1  output  4  decoded BCD, digit 1
oDIG2  output  4  decoded BCD, digit 2
oDIG3  output  4  decoded BCD, digit 3
oDIG_VLD  output  4  per-digit valid flags
oFRAME  output  1  one-cycle pulse when all four digits have been captured since the last pulse
oERR_PAT  output  1  one-cycle pulse: a stable pattern decoded to no legal glyph
oERR_SEL  output  1  one-cycle pulse: more than one iDIG_SEL bit is high

Behaviour:
- Clocking and reset: every register updates on the posedge of clk. While rst=1 at an edge:
  - oDIG0..3=0, oDIG_VLD=0, oFRAME=0, oERR_PAT=0, oERR_SEL=0.
  - Internal registers cleared: prev_sel=0, prev_seg=7'h7F, stab_cnt=0, seen mask=0, state=IDLE.
  - A reset mid-scan discards the partial frame.
- Decode table (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Blank 7F decodes to 4'hF and counts as valid (leading-blank digit).
  - Any other pattern is illegal.
- Match condition: iDIG_SEL is one-hot AND iDIG_SEL==prev_sel AND iSEG7==prev_seg. prev_sel and prev_seg update every cycle.
- State machine:
  - IDLE: iDIG_SEL is zero, or a new pair has just appeared. stab_cnt=0.
  - COUNT: on each match, stab_cnt increments. On the edge where stab_cnt==STABLE_CYC-1 and match holds, perform a capture and go to HELD. A capture fires on the STABLE_CYC-th consecutive match after the pair first appeared.
  - HELD: no further capture while the pair is unchanged. Any mismatch, or iDIG_SEL=0, returns to IDLE (stab_cnt=0).
- Capture for digit n (the bit set in iDIG_SEL); all results are registered and visible after the capture edge:
  - Legal pattern: oDIGn=decode, oDIG_VLD[n]=1, seen[n]=1.
  - Illegal pattern: oDIGn unchanged, oDIG_VLD[n]=0, oERR_PAT=1 for one cycle, seen unchanged.
- Frame:
  - When a legal capture makes seen==4'hF, oFRAME=1 on that same edge and seen clears to 0.
  - Capturing the same digit repeatedly does not advance the frame.
- Select error: when iDIG_SEL has two or more bits set, oERR_SEL=1 for that cycle, stab_cnt=0, state=IDLE, and no capture occurs. The pulse repeats each cycle the condition persists.
- Glitch rejection: a change of either input before STABLE_CYC matches restarts counting from 0.
- All pulse outputs default to 0 on every cycle in which they are not asserted.

Optional Feature:
SEG7_TIMEOUT_EN
- Defined:
  - A counter resets to 0 on every capture (legal or illegal) and on rst, and saturates at TIMEOUT_CYC.
  - On the edge where it reaches TIMEOUT_CYC: oDIG_VLD=0, seen=0, and oERR_SEL pulses once (reused as the "no scan" indication).
  - If a capture and the timeout occur on the same edge, the capture wins and the counter restarts.
- Undefined: no counter logic. oDIG_VLD holds its last values indefinitely.

Test Plan:
- rst=1 for 2 clocks, inputs at any values -> all outputs 0; release with iDIG_SEL=0 for 10 clocks -> outputs stay 0.
- STABLE_CYC=4; hold iDIG_SEL=4'b0001, iSEG7=7'h30 starting at edge k -> oDIG0=3 and oDIG_VLD[0]=1 visible after edge k+4, not after edge k+3; holding 20 more cycles gives no further pulses.
- Scan digits 0..3 with 19, 12, 02, 7F, 6 clocks each, separated by 1 blank clock -> oDIG0..3=4, 5, 6, F; oFRAME pulses exactly once, on the edge of the digit 3 capture.
- Same scan, but digit 2 uses iSEG7 7'h55 -> oERR_PAT one pulse, oDIG_VLD[2]=0, oDIG2 keeps its prior value, no oFRAME.
- iDIG_SEL=4'b0011 for 3 clocks -> oERR_SEL high for 3 cycles, no capture; a digit-0 glitch of 2 clocks -> no capture.
- With SEG7_TIMEOUT_EN and TIMEOUT_CYC=50: capture digit 0, then hold iDIG_SEL=0 -> after 50 clocks oDIG_VLD=0 and one oERR_SEL pulse.
